ms_countdown_timer: RTL and testbench
=====================================

Name: ms_countdown_timer

Overview:
- Parametrised successor to the fixed 1 ms tick generator: a programmable prescaler produces a one-cycle tick at TICK_HZ from CLK_HZ.
- A loadable countdown (in ticks) with start/pause/resume control drives the game's answer time limit.
- Sits between the board clock and game-control FSM; `tick` also feeds display refresh and debounce logic.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency.
- TICK_HZ, 1000, tick rate; DIV = CLK_HZ/TICK_HZ, DIV >= 2, divides exactly.
- CNT_W, 16, countdown width in ticks.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  prescaler gate; 0 freezes prescaler phase.
- load  in  1  pulse: remaining <= load_val, state -> IDLE.
- load_val  in  CNT_W  countdown start value.
- start  in  1  pulse: IDLE -> RUN, or PAUSED -> RUN.
- pause  in  1  pulse: RUN -> PAUSED.
- tick  out  1  one-cycle pulse every DIV enabled cycles.
- remaining  out  CNT_W  current countdown value.
- running  out  1  high in RUN.
- done  out  1  one-cycle pulse on expiry.
- expired  out  1  level; high in EXPIRED.

Behaviour:
- Reset (async, rst=0): prescaler=0, tick=0, remaining=0, reload register=0, state=IDLE, running=0, done=0, expired=0.
- Prescaler counts 0..DIV-1 only while enable=1.
- On an enabled cycle with count==DIV-1, count wraps to 0 and tick is registered high for the next cycle only.
  - First tick is the cycle after the DIV-th enabled cycle following reset.
- enable=0: count holds and tick=0.
- The prescaler free-runs, independent of the FSM. load/start do not rephase it.
- All outputs are registered.
- FSM states: IDLE, RUN, PAUSED, EXPIRED.
- Control priority per cycle: load > start > pause. Lower-priority inputs that cycle are ignored.
- load (any state): remaining <= load_val, reload register <= load_val, state -> IDLE, expired cleared next cycle.
- start in IDLE:
  - remaining != 0: -> RUN.
  - remaining == 0: -> EXPIRED, done pulses next cycle.
- start in PAUSED: -> RUN.
- start in RUN or EXPIRED: ignored.
- pause in RUN: -> PAUSED; remaining holds. pause in any other state: ignored.
- RUN, tick=1:
  - remaining > 1: remaining decrements.
  - remaining == 1: remaining -> 0, state -> EXPIRED, done=1 in the same cycle that remaining first reads 0.
- tick and pause in the same cycle (RUN): the decrement is applied, then the state becomes PAUSED. If that decrement reaches 0, EXPIRED wins and pause is ignored.
- remaining never underflows or wraps. A decrement occurs only in RUN.
- EXPIRED holds until load or reset.
- Async reset mid-count: immediate return to reset values, with no done pulse.

Optional Feature:
- Macro: MS_COUNTDOWN_AUTO_RELOAD_EN.
- Defined: on expiry, done pulses, remaining <= reload register, and state stays RUN (periodic timer). expired never asserts in this case.
  - If the reload register is 0, the block behaves as when undefined.
- Undefined: the block enters EXPIRED as described above.

Decomposition:
- Package ms_timer_pkg holds:
  - state enum typedef (IDLE, RUN, PAUSED, EXPIRED; 2 bits);
  - a constant function computing DIV;
  - a prescaler-width function based on $clog2(DIV).
- Sub-module tick_prescaler (clk, rst, enable -> tick; parameter DIV) is natural and reused by the display-refresh logic. The countdown FSM stays in the top level.

Test Plan (CLK_HZ=10, TICK_HZ=1 so DIV=10; CNT_W=8):
1. Reset, then enable=1 held: tick pulses one cycle wide at cycles 11, 21, 31 after reset release. Drop enable for 5 cycles: next tick is delayed by exactly 5 cycles.
2. load_val=3, load, then start: remaining goes 3->2->1->0 on successive ticks. done pulses once with remaining=0; expired=1 and running=0 thereafter, while ticks continue.
3. load_val=5, start, pause after 2 ticks: remaining=3 holds across 4 ticks. start resumes, and expiry occurs 3 ticks later.
4. load_val=0, then start: EXPIRED with a single done pulse and no decrement. Also assert load and start in the same cycle with load_val=4: result is IDLE with remaining=4.
5. pause coincident with a tick at remaining=1: remaining=0, EXPIRED, done=1, no PAUSED state. Assert rst=0 mid-count: all outputs return to 0 asynchronously.
6. With MS_COUNTDOWN_AUTO_RELOAD_EN and load_val=2: done pulses every 2 ticks, remaining sequence is 2,1,2,1..., and expired stays 0.

Source files
------------

// File: rtl/ms_timer_pkg.sv
// Shared definitions for the millisecond countdown timer and its prescaler:
// FSM state encoding and constant helpers for the divide ratio and counter width.
package ms_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } timer_state_e;

    // Clock cycles per tick; callers guarantee an exact division with result >= 2.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // Bits needed to hold the prescaler phase 0..div-1.
    function automatic int unsigned presc_width(input int unsigned div);
        return (div < 32'd2) ? 32'd1 : $clog2(div);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running tick prescaler: emits a registered one-cycle pulse after every
// DIV enabled cycles. enable=0 freezes the phase and keeps the tick low.
module tick_prescaler
    import ms_timer_pkg::*;
#(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int unsigned  CW   = presc_width(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 32'd1);
    localparam logic [CW-1:0] ONE  = CW'(32'd1);
    localparam logic [CW-1:0] ZERO = CW'(32'd0);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          tick_q;
    logic          tick_d;

    // Next phase and tick: wrap at DIV-1 and flag the wrap for exactly one cycle.
    always_comb begin
        count_d = count_q;
        tick_d  = 1'b0;
        if (enable) begin
            if (count_q == LAST) begin
                count_d = ZERO;
                tick_d  = 1'b1;
            end else begin
                count_d = count_q + ONE;
                tick_d  = 1'b0;
            end
        end else begin
            count_d = count_q;
            tick_d  = 1'b0;
        end
    end

    // Phase and tick registers, cleared asynchronously by the active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= ZERO;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/ms_countdown_timer.sv
// Programmable countdown timer: tick prescaler plus a load/start/pause countdown
// FSM measured in ticks. Optional periodic mode: define MS_COUNTDOWN_AUTO_RELOAD_EN
// to reload the last loaded value on expiry instead of stopping in EXPIRED.
module ms_countdown_timer
    import ms_timer_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned TICK_HZ = 1000,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    output logic             tick,
    output logic [CNT_W-1:0] remaining,
    output logic             running,
    output logic             done,
    output logic             expired
);

    localparam int unsigned      DIV      = calc_div(CLK_HZ, TICK_HZ);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

    logic             tick_s;
    timer_state_e     state_q,     state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] reload_q,    reload_d;
    logic             running_q,   running_d;
    logic             done_q,      done_d;
    logic             expired_q,   expired_d;

    tick_prescaler #(.DIV(DIV)) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .tick   (tick_s)
    );

    // Next-state logic: load beats start beats pause; decrements only in RUN on a tick.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        reload_d    = reload_q;
        done_d      = 1'b0;
        if (load) begin
            remaining_d = load_val;
            reload_d    = load_val;
            state_d     = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (remaining_q != CNT_ZERO) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_EXPIRED;
                            done_d  = 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (tick_s) begin
                        if (remaining_q > CNT_ONE) begin
                            remaining_d = remaining_q - CNT_ONE;
                            state_d     = pause ? ST_PAUSED : ST_RUN;
                        end else begin
                            // Expiry; a value of 0 here is treated as expiry too so it never wraps.
                            done_d = 1'b1;
`ifdef MS_COUNTDOWN_AUTO_RELOAD_EN
                            if (reload_q != CNT_ZERO) begin
                                remaining_d = reload_q;
                                state_d     = pause ? ST_PAUSED : ST_RUN;
                            end else begin
                                remaining_d = CNT_ZERO;
                                state_d     = ST_EXPIRED;
                            end
`else
                            remaining_d = CNT_ZERO;
                            state_d     = ST_EXPIRED;
`endif
                        end
                    end else if (pause) begin
                        state_d = ST_PAUSED;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_PAUSED: begin
                    if (start) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_PAUSED;
                    end
                end
                ST_EXPIRED: begin
                    state_d = ST_EXPIRED;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        running_d = (state_d == ST_RUN);
        expired_d = (state_d == ST_EXPIRED);
    end

    // State and output registers; async reset returns everything to zero/IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            remaining_q <= CNT_ZERO;
            reload_q    <= CNT_ZERO;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            expired_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            reload_q    <= reload_d;
            running_q   <= running_d;
            done_q      <= done_d;
            expired_q   <= expired_d;
        end
    end

    assign tick      = tick_s;
    assign remaining = remaining_q;
    assign running   = running_q;
    assign done      = done_q;
    assign expired   = expired_q;

endmodule

// File: tb/tb_ms_countdown_timer.sv
// Self-checking bench for ms_countdown_timer with DIV=10, CNT_W=8: directed
// scenarios with explicit expectations plus a randomized run against a model.
module tb_ms_countdown_timer;

    localparam int CNT_W = 8;
    localparam int DIV   = 10;
`ifdef MS_COUNTDOWN_AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXP = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0, ld = 1'b0, st = 1'b0, ps = 1'b0;
    logic [CNT_W-1:0] ld_val = '0;
    logic             tick, running, done, expired;
    logic [CNT_W-1:0] remaining;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural reference: enabled-cycle counter modulo DIV, countdown in ticks.
    int m_phase, m_rem, m_reload, m_mode;
    bit m_tick, m_done;

    ms_countdown_timer #(.CLK_HZ(10), .TICK_HZ(1), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .enable(en), .load(ld), .load_val(ld_val),
        .start(st), .pause(ps), .tick(tick), .remaining(remaining),
        .running(running), .done(done), .expired(expired)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_phase = 0; m_rem = 0; m_reload = 0; m_mode = M_IDLE;
        m_tick = 1'b0; m_done = 1'b0;
    endtask

    task automatic model_step();
        bit tick_now;
        tick_now = m_tick;
        if (en) begin
            m_phase = (m_phase + 1) % DIV;
            m_tick  = (m_phase == 0);
        end else begin
            m_tick = 1'b0;
        end
        m_done = 1'b0;
        if (ld) begin
            m_rem = int'(ld_val); m_reload = int'(ld_val); m_mode = M_IDLE;
        end else if (m_mode == M_IDLE) begin
            if (st) begin
                if (m_rem > 0) m_mode = M_RUN;
                else begin m_mode = M_EXP; m_done = 1'b1; end
            end
        end else if (m_mode == M_PAUSED) begin
            if (st) m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (tick_now && m_rem > 1) begin
                m_rem = m_rem - 1;
                if (ps) m_mode = M_PAUSED;
            end else if (tick_now) begin
                m_done = 1'b1;
                if (AUTO && m_reload > 0) begin
                    m_rem = m_reload;
                    if (ps) m_mode = M_PAUSED;
                end else begin
                    m_rem = 0; m_mode = M_EXP;
                end
            end else if (ps) begin
                m_mode = M_PAUSED;
            end
        end
    endtask

    // One clock: DUT and model both consume the current inputs, then sample at +1.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b1; ld = 1'b0; st = 1'b0; ps = 1'b0;
        #2;
        n_cmp++;
        if ({tick, remaining, running, done, expired} !== 12'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b required 0", {tick, remaining, running, done, expired});
        end
        repeat (3) @(posedge clk);
        #3;
        model_reset();
        rst = 1'b1;
    endtask

    task automatic test_prescaler();
        bit exp_t;
        for (int k = 1; k <= 60; k++) begin
            en = !(k >= 36 && k <= 40);
            cycle();
            if (k <= 35)      exp_t = (k % 10 == 0);
            else if (k <= 40) exp_t = 1'b0;
            else              exp_t = ((k - 5) % 10 == 0);
            n_cmp++;
            if (tick !== exp_t) begin
                n_bad++;
                $display("FAIL tick_edge%0d: got %b required %b", k, tick, exp_t);
            end
        end
        en = 1'b1;
    endtask

    task automatic test_countdown();
        int prev, obs_seq, done_cnt, rem_at_done, ticks, extra_done;
        int seq[$];
        ld_val = 8'd3; ld = 1'b1; cycle(); ld = 1'b0;
        n_cmp++;
        if (remaining !== 8'd3 || running !== 1'b0) begin
            n_bad++; $display("FAIL cd_load: got rem=%0d run=%b required rem=3 run=0", remaining, running);
        end
        st = 1'b1; cycle(); st = 1'b0;
        n_cmp++;
        if (running !== 1'b1) begin n_bad++; $display("FAIL cd_start: got run=%b required 1", running); end
        prev = 3; done_cnt = 0; rem_at_done = -1;
        for (int i = 0; i < 60; i++) begin
            cycle();
            if (int'(remaining) != prev) begin seq.push_back(int'(remaining)); prev = int'(remaining); end
            if (done === 1'b1) begin done_cnt++; rem_at_done = int'(remaining); end
            if (expired === 1'b1) break;
        end
        obs_seq = (seq.size() == 3) ? seq[0] * 100 + seq[1] * 10 + seq[2] : -1;
        n_cmp++;
        if (obs_seq != 210) begin n_bad++; $display("FAIL cd_sequence: got %0d required 210", obs_seq); end
        n_cmp++;
        if (done_cnt != 1 || rem_at_done != 0) begin
            n_bad++; $display("FAIL cd_done: got count=%0d rem=%0d required count=1 rem=0", done_cnt, rem_at_done);
        end
        ticks = 0; extra_done = 0;
        for (int i = 0; i < 25; i++) begin
            cycle();
            if (tick === 1'b1) ticks++;
            if (done === 1'b1) extra_done++;
        end
        n_cmp++;
        if (expired !== 1'b1 || running !== 1'b0 || extra_done != 0 || ticks < 2) begin
            n_bad++;
            $display("FAIL cd_hold: got exp=%b run=%b extra_done=%0d ticks=%0d required 1 0 0 >=2",
                     expired, running, extra_done, ticks);
        end
    endtask

    task automatic test_pause_resume();
        bit found, held_ok, got;
        int ticks;
        ld_val = 8'd5; ld = 1'b1; cycle(); ld = 1'b0;
        st = 1'b1; cycle(); st = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (remaining === 8'd3) begin found = 1'b1; break; end
        end
        n_cmp++;
        if (!found) begin n_bad++; $display("FAIL pr_reach3: got rem=%0d required 3", remaining); end
        ps = 1'b1; cycle(); ps = 1'b0;
        n_cmp++;
        if (running !== 1'b0 || remaining !== 8'd3) begin
            n_bad++; $display("FAIL pr_pause: got run=%b rem=%0d required 0 3", running, remaining);
        end
        ticks = 0; held_ok = 1'b1;
        for (int i = 0; i < 60 && ticks < 4; i++) begin
            cycle();
            if (tick === 1'b1) ticks++;
            if (remaining !== 8'd3 || running !== 1'b0) held_ok = 1'b0;
        end
        n_cmp++;
        if (ticks != 4 || !held_ok) begin
            n_bad++; $display("FAIL pr_hold: got ticks=%0d held=%b required 4 1", ticks, held_ok);
        end
        st = 1'b1; cycle(); st = 1'b0;
        n_cmp++;
        if (running !== 1'b1) begin n_bad++; $display("FAIL pr_resume: got run=%b required 1", running); end
        ticks = 0; got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            cycle();
            if (done === 1'b1) begin got = 1'b1; break; end
            if (tick === 1'b1) ticks++;
        end
        n_cmp++;
        if (!got || ticks != 3 || remaining !== 8'd0 || expired !== 1'b1) begin
            n_bad++;
            $display("FAIL pr_expire: got done=%b ticks=%0d rem=%0d exp=%b required 1 3 0 1",
                     got, ticks, remaining, expired);
        end
    endtask

    task automatic test_zero_and_priority();
        bit held_ok;
        ld_val = 8'd0; ld = 1'b1; cycle(); ld = 1'b0;
        st = 1'b1; cycle(); st = 1'b0;
        n_cmp++;
        if (done !== 1'b1 || expired !== 1'b1 || remaining !== 8'd0 || running !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_start: got done=%b exp=%b rem=%0d run=%b required 1 1 0 0",
                     done, expired, remaining, running);
        end
        cycle();
        n_cmp++;
        if (done !== 1'b0 || expired !== 1'b1) begin
            n_bad++; $display("FAIL zero_single_done: got done=%b exp=%b required 0 1", done, expired);
        end
        ld_val = 8'd4; ld = 1'b1; st = 1'b1; cycle(); ld = 1'b0; st = 1'b0;
        n_cmp++;
        if (remaining !== 8'd4 || running !== 1'b0 || expired !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL load_beats_start: got rem=%0d run=%b exp=%b done=%b required 4 0 0 0",
                     remaining, running, expired, done);
        end
        held_ok = 1'b1;
        for (int i = 0; i < 15; i++) begin
            cycle();
            if (remaining !== 8'd4 || running !== 1'b0) held_ok = 1'b0;
        end
        n_cmp++;
        if (!held_ok) begin n_bad++; $display("FAIL idle_hold: got rem=%0d required 4", remaining); end
    endtask

    task automatic test_pause_at_expiry();
        bit found;
        ld_val = 8'd1; ld = 1'b1; cycle(); ld = 1'b0;
        st = 1'b1; cycle(); st = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (tick === 1'b1 && running === 1'b1) begin found = 1'b1; break; end
            cycle();
        end
        n_cmp++;
        if (!found || remaining !== 8'd1) begin
            n_bad++; $display("FAIL pe_setup: got found=%b rem=%0d required 1 1", found, remaining);
        end
        ps = 1'b1; cycle(); ps = 1'b0;
        n_cmp++;
        if (remaining !== 8'd0 || done !== 1'b1 || expired !== 1'b1 || running !== 1'b0) begin
            n_bad++;
            $display("FAIL pe_expiry_wins: got rem=%0d done=%b exp=%b run=%b required 0 1 1 0",
                     remaining, done, expired, running);
        end
        cycle();
        n_cmp++;
        if (expired !== 1'b1 || done !== 1'b0) begin
            n_bad++; $display("FAIL pe_not_paused: got exp=%b done=%b required 1 0", expired, done);
        end
    endtask

    task automatic test_reset_midcount();
        bit done_seen;
        ld_val = 8'd200; ld = 1'b1; cycle(); ld = 1'b0;
        st = 1'b1; cycle(); st = 1'b0;
        repeat (15) cycle();
        n_cmp++;
        if (running !== 1'b1) begin n_bad++; $display("FAIL rm_running: got %b required 1", running); end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({tick, remaining, running, done, expired} !== 12'd0) begin
            n_bad++;
            $display("FAIL rm_async_clear: got %b required 0", {tick, remaining, running, done, expired});
        end
        model_reset();
        done_seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done !== 1'b0) done_seen = 1'b1;
        end
        n_cmp++;
        if (done_seen) begin n_bad++; $display("FAIL rm_no_done: got done pulse required none"); end
        rst = 1'b1;
    endtask

    task automatic test_auto_reload();
        int dn;
        bit ok;
        ld_val = 8'd2; ld = 1'b1; cycle(); ld = 1'b0;
        st = 1'b1; cycle(); st = 1'b0;
        dn = 0; ok = 1'b1;
`ifdef MS_COUNTDOWN_AUTO_RELOAD_EN
        for (int i = 0; i < 70; i++) begin
            cycle();
            if (done === 1'b1) begin dn++; if (remaining !== 8'd2) ok = 1'b0; end
            if (expired !== 1'b0 || running !== 1'b1 || (remaining !== 8'd1 && remaining !== 8'd2)) ok = 1'b0;
        end
        n_cmp++;
        if (dn < 3 || !ok) begin
            n_bad++; $display("FAIL ar_periodic: got dones=%0d ok=%b required >=3 1", dn, ok);
        end
`else
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (done === 1'b1) dn++;
            if (expired === 1'b1) break;
        end
        n_cmp++;
        if (dn != 1 || expired !== 1'b1 || remaining !== 8'd0) begin
            n_bad++;
            $display("FAIL ar_oneshot: got dones=%0d exp=%b rem=%0d required 1 1 0", dn, expired, remaining);
        end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            en     = ($urandom_range(0, 9) != 0);
            ld     = ($urandom_range(0, 39) == 0);
            st     = ($urandom_range(0, 11) == 0);
            ps     = ($urandom_range(0, 15) == 0);
            ld_val = CNT_W'($urandom_range(0, 6));
            cycle();
            n_cmp++;
            if (tick !== m_tick || int'(remaining) != m_rem || running !== (m_mode == M_RUN) ||
                done !== m_done || expired !== (m_mode == M_EXP)) begin
                n_bad++;
                $display("FAIL rand_cyc%0d: got t=%b rem=%0d run=%b done=%b exp=%b required t=%b rem=%0d run=%b done=%b exp=%b",
                         i, tick, remaining, running, done, expired,
                         m_tick, m_rem, (m_mode == M_RUN), m_done, (m_mode == M_EXP));
            end
        end
        ld = 1'b0; st = 1'b0; ps = 1'b0; en = 1'b1;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_prescaler();
        if (!AUTO) begin
            test_countdown();
            test_pause_resume();
        end
        test_zero_and_priority();
        if (!AUTO) begin
            test_pause_at_expiry();
        end
        test_reset_midcount();
        test_auto_reload();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
